// File: rtl/id_ctrl_stage_pkg.sv
// Shared types and constants for the ID->EX control stage.
// CTRL_MEXT_EN (optional) enables RV32M decode and the divide occupancy counter.
package id_ctrl_stage_pkg;

    localparam int unsigned ALU_W     = 5;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned MDU_CNT_W = 4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    localparam logic [ALU_W-1:0] ALU_ADD    = 5'd0;
    localparam logic [ALU_W-1:0] ALU_SUB    = 5'd1;
    localparam logic [ALU_W-1:0] ALU_SLL    = 5'd2;
    localparam logic [ALU_W-1:0] ALU_SLT    = 5'd3;
    localparam logic [ALU_W-1:0] ALU_SLTU   = 5'd4;
    localparam logic [ALU_W-1:0] ALU_XOR    = 5'd5;
    localparam logic [ALU_W-1:0] ALU_SRL    = 5'd6;
    localparam logic [ALU_W-1:0] ALU_SRA    = 5'd7;
    localparam logic [ALU_W-1:0] ALU_OR     = 5'd8;
    localparam logic [ALU_W-1:0] ALU_AND    = 5'd9;
    localparam logic [ALU_W-1:0] ALU_MUL    = 5'd10;
    localparam logic [ALU_W-1:0] ALU_MULH   = 5'd11;
    localparam logic [ALU_W-1:0] ALU_MULHSU = 5'd12;
    localparam logic [ALU_W-1:0] ALU_MULHU  = 5'd13;
    localparam logic [ALU_W-1:0] ALU_DIV    = 5'd14;
    localparam logic [ALU_W-1:0] ALU_DIVU   = 5'd15;
    localparam logic [ALU_W-1:0] ALU_REM    = 5'd16;
    localparam logic [ALU_W-1:0] ALU_REMU   = 5'd17;

    typedef struct packed {
        logic [ALU_W-1:0] alu_opcode;
        logic             op1_sel;
        logic             op2_sel;
        logic             br_unsign;
        logic             branch;
        logic             jmp;
        logic             mem_to_reg;
        logic             mem_rden;
        logic             mem_wren;
        logic             rd_wren;
        logic             is_ctrl;
        logic [2:0]       funct3;
        logic [REG_W-1:0] rd_addr;
        logic [REG_W-1:0] rs1_addr;
        logic [REG_W-1:0] rs2_addr;
    } ctrl_bundle_t;

    // funct3 -> base ALU op; alt selects sub/sra.
    function automatic logic [ALU_W-1:0] base_alu(input logic [2:0] f3, input logic alt);
        logic [ALU_W-1:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_ctrl_stage_ctrl_decoder.sv
// Combinational instruction decoder: instruction word -> control bundle.
// CTRL_MEXT_EN selects RV32M decode; otherwise funct7=0000001 is illegal.
module ctrl_decoder
    import id_ctrl_stage_pkg::*;
(
    input  logic [31:0]  i_instr,
    output ctrl_bundle_t o_ctrl,
    output logic         o_illegal,
    output logic         o_uses_rs1,
    output logic         o_uses_rs2,
    output logic         o_is_div
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = i_instr[6:0];
    assign f3     = i_instr[14:12];
    assign f7     = i_instr[31:25];

    always_comb begin
        o_ctrl            = '0;
        o_ctrl.alu_opcode = ALU_ADD;
        o_ctrl.funct3     = f3;
        o_ctrl.rd_addr    = i_instr[11:7];
        o_ctrl.rs1_addr   = i_instr[19:15];
        o_ctrl.rs2_addr   = i_instr[24:20];
        o_illegal         = 1'b0;
        o_uses_rs1        = 1'b1;
        o_uses_rs2        = 1'b0;
        o_is_div          = 1'b0;
        case (opcode)
            OPC_LUI: begin
                // lui adds its immediate to x0
                o_ctrl.rs1_addr = '0;
                o_ctrl.op2_sel  = 1'b1;
                o_ctrl.rd_wren  = 1'b1;
                o_uses_rs1      = 1'b0;
            end
            OPC_AUIPC: begin
                o_ctrl.op1_sel = 1'b1;
                o_ctrl.op2_sel = 1'b1;
                o_ctrl.rd_wren = 1'b1;
                o_uses_rs1     = 1'b0;
            end
            OPC_JAL: begin
                o_ctrl.op1_sel = 1'b1;
                o_ctrl.op2_sel = 1'b1;
                o_ctrl.jmp     = 1'b1;
                o_ctrl.rd_wren = 1'b1;
                o_ctrl.is_ctrl = 1'b1;
                o_uses_rs1     = 1'b0;
            end
            OPC_JALR: begin
                o_ctrl.op2_sel = 1'b1;
                o_ctrl.jmp     = 1'b1;
                o_ctrl.rd_wren = 1'b1;
                o_ctrl.is_ctrl = 1'b1;
                o_illegal      = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                o_ctrl.op1_sel   = 1'b1;
                o_ctrl.op2_sel   = 1'b1;
                o_ctrl.branch    = 1'b1;
                o_ctrl.is_ctrl   = 1'b1;
                o_ctrl.br_unsign = f3[1];
                o_uses_rs2       = 1'b1;
                o_illegal        = (f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                o_ctrl.op2_sel    = 1'b1;
                o_ctrl.mem_rden   = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.rd_wren    = 1'b1;
            end
            OPC_STORE: begin
                o_ctrl.op2_sel  = 1'b1;
                o_ctrl.mem_wren = 1'b1;
                o_uses_rs2      = 1'b1;
            end
            OPC_OPIMM: begin
                o_ctrl.op2_sel    = 1'b1;
                o_ctrl.rd_wren    = 1'b1;
                o_ctrl.alu_opcode = base_alu(f3, (f3 == 3'b101) && f7[5]);
                if (f3 == 3'b001)
                    o_illegal = (f7 != FUNCT7_BASE);
                else if (f3 == 3'b101)
                    o_illegal = (f7 != FUNCT7_BASE) && (f7 != FUNCT7_ALT);
            end
            OPC_OP: begin
                o_ctrl.rd_wren = 1'b1;
                o_uses_rs2     = 1'b1;
                if (f7 == FUNCT7_BASE) begin
                    o_ctrl.alu_opcode = base_alu(f3, 1'b0);
                end else if ((f7 == FUNCT7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))) begin
                    o_ctrl.alu_opcode = base_alu(f3, 1'b1);
                end else if (f7 == FUNCT7_MEXT) begin
`ifdef CTRL_MEXT_EN
                    o_ctrl.alu_opcode = ALU_MUL + ALU_W'(f3);
                    o_is_div          = f3[2];
`else
                    o_illegal = 1'b1;
`endif
                end else begin
                    o_illegal = 1'b1;
                end
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ctrl_stage.sv
// ID->EX pipeline register with load-use bubble insertion, stall/flush and
// optional multi-cycle divide occupancy (CTRL_MEXT_EN).
module id_ctrl_stage
    import id_ctrl_stage_pkg::*;
#(
    parameter int unsigned ALU_OP_W   = 5,
    parameter int unsigned DIV_CYCLES = 4,
    parameter int unsigned HAZARD_EN  = 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [31:0]         i_instr,
    input  logic                i_valid,
    input  logic                i_stall_ex,
    input  logic                i_flush,
    output logic                o_stall_if,
    output logic                o_valid,
    output logic [ALU_OP_W-1:0] o_alu_opcode,
    output logic                o_op1_sel,
    output logic                o_op2_sel,
    output logic                o_br_unsign,
    output logic                o_branch,
    output logic                o_jmp,
    output logic                o_mem_to_reg,
    output logic                o_mem_rden,
    output logic                o_mem_wren,
    output logic                o_rd_wren,
    output logic                o_is_ctrl,
    output logic [2:0]          o_funct3,
    output logic [REG_W-1:0]    o_rd_addr,
    output logic [REG_W-1:0]    o_rs1_addr,
    output logic [REG_W-1:0]    o_rs2_addr,
    output logic                o_illegal,
    output logic                o_mdu_busy
);

    localparam logic [MDU_CNT_W-1:0] DIV_LOAD = MDU_CNT_W'(DIV_CYCLES - 1);

    ctrl_bundle_t dec_ctrl;
    logic         dec_illegal;
    logic         dec_uses_rs1;
    logic         dec_uses_rs2;
    logic         dec_is_div;

    ctrl_decoder u_dec (
        .i_instr    (i_instr),
        .o_ctrl     (dec_ctrl),
        .o_illegal  (dec_illegal),
        .o_uses_rs1 (dec_uses_rs1),
        .o_uses_rs2 (dec_uses_rs2),
        .o_is_div   (dec_is_div)
    );

    ctrl_bundle_t ctrl_q, ctrl_d;
    logic         valid_q, valid_d;
    logic         illegal_q, illegal_d;
    logic         mdu_hold;
    logic         hz;
    logic         rs_match;

`ifdef CTRL_MEXT_EN
    logic [MDU_CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
    logic                 mdu_busy_q, mdu_busy_d;

    assign mdu_hold   = (mdu_cnt_q != '0);
    assign o_mdu_busy = mdu_busy_q;
`else
    logic unused_mdu;

    assign unused_mdu = ^{dec_is_div, DIV_LOAD};
    assign mdu_hold   = 1'b0;
    assign o_mdu_busy = 1'b0;
`endif

    // Load in EX whose destination feeds a source the incoming instruction reads.
    assign rs_match = (dec_uses_rs1 && (ctrl_q.rd_addr == dec_ctrl.rs1_addr)) ||
                      (dec_uses_rs2 && (ctrl_q.rd_addr == dec_ctrl.rs2_addr));
    assign hz = (HAZARD_EN != 0) && i_valid && valid_q && ctrl_q.mem_rden &&
                (ctrl_q.rd_addr != '0) && rs_match;

    assign o_stall_if = !i_flush && (i_stall_ex || hz || mdu_hold);

    always_comb begin
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
`ifdef CTRL_MEXT_EN
        mdu_cnt_d  = mdu_cnt_q;
        mdu_busy_d = mdu_busy_q;
`endif
        if (i_flush) begin
            valid_d = 1'b0;
`ifdef CTRL_MEXT_EN
            mdu_cnt_d  = '0;
            mdu_busy_d = 1'b0;
`endif
        end else if (i_stall_ex || mdu_hold) begin
`ifdef CTRL_MEXT_EN
            if (mdu_hold) begin
                mdu_cnt_d = mdu_cnt_q - MDU_CNT_W'(1);
                if (mdu_cnt_q == MDU_CNT_W'(1))
                    mdu_busy_d = 1'b0;
            end
`endif
        end else if (hz) begin
            valid_d = 1'b0;
        end else begin
            ctrl_d    = dec_ctrl;
            valid_d   = i_valid;
            illegal_d = dec_illegal && i_valid;
            if (!i_valid || dec_illegal) begin
                ctrl_d.rd_wren  = 1'b0;
                ctrl_d.mem_wren = 1'b0;
                ctrl_d.mem_rden = 1'b0;
            end
            if (dec_illegal) begin
                ctrl_d.branch = 1'b0;
                ctrl_d.jmp    = 1'b0;
            end
`ifdef CTRL_MEXT_EN
            if (i_valid && dec_is_div && !dec_illegal) begin
                mdu_cnt_d  = DIV_LOAD;
                mdu_busy_d = 1'b1;
            end else begin
                mdu_busy_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
`ifdef CTRL_MEXT_EN
            mdu_cnt_q  <= '0;
            mdu_busy_q <= 1'b0;
`endif
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
`ifdef CTRL_MEXT_EN
            mdu_cnt_q  <= mdu_cnt_d;
            mdu_busy_q <= mdu_busy_d;
`endif
        end
    end

    assign o_valid      = valid_q;
    assign o_alu_opcode = ALU_OP_W'(ctrl_q.alu_opcode);
    assign o_op1_sel    = ctrl_q.op1_sel;
    assign o_op2_sel    = ctrl_q.op2_sel;
    assign o_br_unsign  = ctrl_q.br_unsign;
    assign o_branch     = ctrl_q.branch;
    assign o_jmp        = ctrl_q.jmp;
    assign o_mem_to_reg = ctrl_q.mem_to_reg;
    assign o_mem_rden   = ctrl_q.mem_rden;
    assign o_mem_wren   = ctrl_q.mem_wren;
    assign o_rd_wren    = ctrl_q.rd_wren;
    assign o_is_ctrl    = ctrl_q.is_ctrl;
    assign o_funct3     = ctrl_q.funct3;
    assign o_rd_addr    = ctrl_q.rd_addr;
    assign o_rs1_addr   = ctrl_q.rs1_addr;
    assign o_rs2_addr   = ctrl_q.rs2_addr;
    assign o_illegal    = illegal_q;

endmodule
